// File: rtl/upp_arb_pkg.sv
// Shared definitions for the uPP channel arbiter: channel count, default widths,
// FSM state encodings and a small channel-to-one-hot helper.
package upp_arb_pkg;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned PEND_W_DEF = 4;
  localparam int unsigned GAP_W      = 9;
  localparam int unsigned TIMEOUT_W  = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  typedef enum logic [1:0] {
    StIdle     = ST_IDLE,
    StGrant    = ST_GRANT,
    StWaitDone = ST_WAIT_DONE,
    StGap      = ST_GAP
  } arbState_t;

  function automatic logic [NUM_CH-1:0] chOneHot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/upp_frame_counter.sv
// Saturating pending-frame counter for one channel. Increment and decrement in
// the same cycle cancel; an increment at full scale holds the count and sets a
// sticky overflow flag. iClr forces the count to zero and drops any increment.
module upp_frame_counter
  import upp_arb_pkg::*;
#(
  parameter int unsigned PEND_W = PEND_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iInc,
  input  logic              iDec,
  input  logic              iClr,
  output logic [PEND_W-1:0] oCount,
  output logic              oOverflow
);

  localparam logic [PEND_W-1:0] MaxCount = '1;

  logic [PEND_W-1:0] countQ, countD;
  logic              ovfQ, ovfD;

  // Next count: clear beats everything, then the inc/dec combination.
  always_comb begin
    countD = countQ;
    ovfD   = ovfQ;
    if (iClr) begin
      countD = '0;
    end else if (iInc && !iDec) begin
      if (countQ == MaxCount) begin
        ovfD = 1'b1;
      end else begin
        countD = countQ + PEND_W'(1);
      end
    end else if (iDec && !iInc && (countQ != '0)) begin
      countD = countQ - PEND_W'(1);
    end
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      countQ <= '0;
      ovfQ   <= 1'b0;
    end else begin
      countQ <= countD;
      ovfQ   <= ovfD;
    end
  end

  assign oCount    = countQ;
  assign oOverflow = ovfQ;

endmodule

// File: rtl/upp_channel_arbiter.sv
// Round-robin arbiter sharing the uPP transmit reader between two BLVDS channel
// FIFOs. Grants one channel per frame, steers rdreq/data to it, enforces an
// inter-frame gap and flushes the granted FIFO if the reader stalls.
// Build option: define UPP_ARB_DEPTH_PRIO_EN to let the deeper queue win when
// both channels are eligible (equal depths still fall back to round-robin).
module upp_channel_arbiter
  import upp_arb_pkg::*;
#(
  parameter logic [GAP_W-1:0]     GAP_CYCLES = 9'd100,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT    = 16'd50000,
  parameter int unsigned          PEND_W     = PEND_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [1:0]        iFRAME_END,
  input  logic [1:0]        iCH_ENA,
  input  logic [15:0]       iFIFO_OUT_0,
  input  logic [15:0]       iFIFO_OUT_1,
  input  logic              iRD_REQ,
  input  logic              iDONE,
  output logic              oSTART,
  output logic              oSEL_CHANNEL,
  output logic [15:0]       oFIFO_OUT,
  output logic [1:0]        oRD_REQ,
  output logic [1:0]        oACLR_FIFO,
  output logic [PEND_W-1:0] oPEND_0,
  output logic [PEND_W-1:0] oPEND_1,
  output logic [1:0]        oOVERFLOW,
  output logic              oTIMEOUT,
  output logic              oBUSY
);

  arbState_t             stateQ, stateD;
  logic                  selQ, selD;
  logic                  lastQ, lastD;
  logic [TIMEOUT_W-1:0]  wdogQ, wdogD;
  logic [GAP_W-1:0]      gapQ, gapD;
  logic                  timeoutQ, timeoutD;

  logic [PEND_W-1:0]     pend [NUM_CH];
  logic [NUM_CH-1:0]     ovf;
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     grantDec;
  logic [NUM_CH-1:0]     abortClr;
  logic                  winner;
  logic                  wdogHit;
  logic                  gapDone;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_cnt
    upp_frame_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iInc      (iFRAME_END[g]),
      .iDec      (grantDec[g]),
      .iClr      (abortClr[g]),
      .oCount    (pend[g]),
      .oOverflow (ovf[g])
    );
    assign elig[g] = (pend[g] != '0) && iCH_ENA[g];
  end

  // Pick the next channel; on a tie the channel not served last wins.
  always_comb begin
    winner = 1'b0;
    case (elig)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11: begin
`ifdef UPP_ARB_DEPTH_PRIO_EN
        if (pend[1] > pend[0]) begin
          winner = 1'b1;
        end else if (pend[0] > pend[1]) begin
          winner = 1'b0;
        end else begin
          winner = ~lastQ;
        end
`else
        winner = ~lastQ;
`endif
      end
      default: winner = 1'b0;
    endcase
  end

  // Watchdog fires on the cycle that would bring the count up to TIMEOUT.
  assign wdogHit = ({1'b0, wdogQ} + 17'd1) >= {1'b0, TIMEOUT};
  // GAP lasts GAP_CYCLES cycles, but never less than one.
  assign gapDone = ({1'b0, gapQ} + 10'd1) >= {1'b0, GAP_CYCLES};

  // Next-state and per-state outputs.
  always_comb begin
    stateD   = stateQ;
    selD     = selQ;
    lastD    = lastQ;
    wdogD    = wdogQ;
    gapD     = gapQ;
    timeoutD = timeoutQ;
    grantDec = '0;
    abortClr = '0;
    oSTART   = 1'b0;
    oBUSY    = 1'b0;
    oRD_REQ  = '0;
    case (stateQ)
      StIdle: begin
        if (|elig) begin
          selD   = winner;
          stateD = StGrant;
        end
      end
      StGrant: begin
        oSTART   = 1'b1;
        oBUSY    = 1'b1;
        grantDec = chOneHot(selQ);
        lastD    = selQ;
        wdogD    = '0;
        gapD     = '0;
        stateD   = StWaitDone;
      end
      StWaitDone: begin
        oBUSY   = 1'b1;
        oRD_REQ = iRD_REQ ? chOneHot(selQ) : '0;
        if (iDONE) begin
          stateD = StGap;
        end else if (wdogHit) begin
          abortClr = chOneHot(selQ);
          timeoutD = 1'b1;
          stateD   = StGap;
        end else begin
          wdogD = wdogQ + 16'd1;
        end
      end
      StGap: begin
        if (gapDone) begin
          stateD = StIdle;
        end else begin
          gapD = gapQ + 9'd1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State and control registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ   <= StIdle;
      selQ     <= 1'b0;
      lastQ    <= 1'b1;
      wdogQ    <= '0;
      gapQ     <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      selQ     <= selD;
      lastQ    <= lastD;
      wdogQ    <= wdogD;
      gapQ     <= gapD;
      timeoutQ <= timeoutD;
    end
  end

  // Reset abandons a frame silently, so the flush pulse is masked while iRST is high.
  assign oACLR_FIFO   = iRST ? '0 : abortClr;
  assign oSEL_CHANNEL = selQ;
  assign oFIFO_OUT    = selQ ? iFIFO_OUT_1 : iFIFO_OUT_0;
  assign oPEND_0      = pend[0];
  assign oPEND_1      = pend[1];
  assign oOVERFLOW    = ovf;
  assign oTIMEOUT     = timeoutQ;

endmodule

// File: tb/tb_upp_channel_arbiter.sv
// Self-checking bench for upp_channel_arbiter (GAP_CYCLES=5, TIMEOUT=20, PEND_W=4).
module tb_upp_channel_arbiter;

  localparam int GAP  = 5;
  localparam int TO   = 20;
  localparam int PMAX = 15;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [1:0]  iFRAME_END = 2'b00;
  logic [1:0]  iCH_ENA = 2'b00;
  logic [15:0] iFIFO_OUT_0 = 16'h0000;
  logic [15:0] iFIFO_OUT_1 = 16'h0000;
  logic        iRD_REQ = 1'b0;
  logic        iDONE = 1'b0;
  logic        oSTART, oSEL_CHANNEL, oTIMEOUT, oBUSY;
  logic [15:0] oFIFO_OUT;
  logic [1:0]  oRD_REQ, oACLR_FIFO, oOVERFLOW;
  logic [3:0]  oPEND_0, oPEND_1;

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  upp_channel_arbiter #(
    .GAP_CYCLES (9'd5),
    .TIMEOUT    (16'd20),
    .PEND_W     (4)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iFRAME_END   (iFRAME_END),
    .iCH_ENA      (iCH_ENA),
    .iFIFO_OUT_0  (iFIFO_OUT_0),
    .iFIFO_OUT_1  (iFIFO_OUT_1),
    .iRD_REQ      (iRD_REQ),
    .iDONE        (iDONE),
    .oSTART       (oSTART),
    .oSEL_CHANNEL (oSEL_CHANNEL),
    .oFIFO_OUT    (oFIFO_OUT),
    .oRD_REQ      (oRD_REQ),
    .oACLR_FIFO   (oACLR_FIFO),
    .oPEND_0      (oPEND_0),
    .oPEND_1      (oPEND_1),
    .oOVERFLOW    (oOVERFLOW),
    .oTIMEOUT     (oTIMEOUT),
    .oBUSY        (oBUSY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 grant, 2 frame in flight, 3 gap.
  int mPhase, mSel, mLast, mAge, mGapLeft, mTo;
  int mPend [2];
  int mOvf [2];
  bit mValid = 1'b0;

  function automatic int pickWinner();
    bit e0, e1;
    e0 = (mPend[0] != 0) && iCH_ENA[0];
    e1 = (mPend[1] != 0) && iCH_ENA[1];
    if (e0 && !e1) return 0;
    if (e1 && !e0) return 1;
`ifdef UPP_ARB_DEPTH_PRIO_EN
    if (mPend[1] > mPend[0]) return 1;
    if (mPend[0] > mPend[1]) return 0;
`endif
    return 1 - mLast;
  endfunction

  function automatic bit anyElig();
    return ((mPend[0] != 0) && iCH_ENA[0]) || ((mPend[1] != 0) && iCH_ENA[1]);
  endfunction

  function automatic bit abortNow();
    return (mPhase == 2) && !iDONE && (mAge == TO) && !iRST;
  endfunction

  always @(posedge iCLK) begin
    int grantCh;
    bit abort;
    grantCh = -1;
    abort   = 1'b0;
    if (iRST) begin
      mPhase = 0; mSel = 0; mLast = 1; mAge = 0; mGapLeft = 0; mTo = 0;
      mPend[0] = 0; mPend[1] = 0; mOvf[0] = 0; mOvf[1] = 0;
      mValid = 1'b1;
    end else if (mValid) begin
      abort = abortNow();
      case (mPhase)
        0: if (anyElig()) begin mSel = pickWinner(); mPhase = 1; end
        1: begin grantCh = mSel; mLast = mSel; mAge = 1; mPhase = 2; end
        2: begin
          if (iDONE || abort) begin
            mPhase = 3;
            mGapLeft = (GAP == 0) ? 1 : GAP;
            if (abort) mTo = 1;
          end else begin
            mAge++;
          end
        end
        default: begin
          mGapLeft--;
          if (mGapLeft == 0) mPhase = 0;
        end
      endcase
      for (int c = 0; c < 2; c++) begin
        if (abort && (c == mSel)) begin
          mPend[c] = 0;
        end else if (iFRAME_END[c] && (grantCh != c)) begin
          if (mPend[c] == PMAX) mOvf[c] = 1;
          else mPend[c]++;
        end else if (!iFRAME_END[c] && (grantCh == c) && (mPend[c] != 0)) begin
          mPend[c]--;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge iCLK) begin
    if (mValid) begin
      logic [1:0] oneHot;
      oneHot = (mSel == 1) ? 2'b10 : 2'b01;
      check("cyc_oSTART", {31'd0, oSTART}, (mPhase == 1) ? 1 : 0);
      check("cyc_oBUSY", {31'd0, oBUSY}, (mPhase == 1 || mPhase == 2) ? 1 : 0);
      check("cyc_oSEL_CHANNEL", {31'd0, oSEL_CHANNEL}, mSel);
      check("cyc_oRD_REQ", {30'd0, oRD_REQ}, (mPhase == 2 && iRD_REQ) ? {30'd0, oneHot} : 0);
      check("cyc_oACLR_FIFO", {30'd0, oACLR_FIFO}, abortNow() ? {30'd0, oneHot} : 0);
      check("cyc_oFIFO_OUT", {16'd0, oFIFO_OUT}, {16'd0, (mSel == 1) ? iFIFO_OUT_1 : iFIFO_OUT_0});
      check("cyc_oPEND_0", {28'd0, oPEND_0}, mPend[0]);
      check("cyc_oPEND_1", {28'd0, oPEND_1}, mPend[1]);
      check("cyc_oOVERFLOW", {30'd0, oOVERFLOW}, {30'd0, mOvf[1][0], mOvf[0][0]});
      check("cyc_oTIMEOUT", {31'd0, oTIMEOUT}, mTo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic doReset();
    step();
    iRST = 1'b1; iFRAME_END = 2'b00; iCH_ENA = 2'b00; iDONE = 1'b0; iRD_REQ = 1'b0;
    step();
    iRST = 1'b0;
  endtask

  task automatic pulseFrame(input logic [1:0] m);
    step();
    iFRAME_END = m;
    step();
    iFRAME_END = 2'b00;
  endtask

  // Returns at the negedge of the grant cycle, or ch=-1 after 200 cycles.
  task automatic waitStart(output int ch);
    ch = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge iCLK);
      if (oSTART === 1'b1) begin
        ch = int'(oSEL_CHANNEL);
        break;
      end
    end
    if (ch < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_start: got no oSTART in 200 cycles, expected a grant");
    end
  endtask

  task automatic finishFrame();
    step();
    iRD_REQ = 1'b1;
    step();
    iRD_REQ = 1'b0;
    iDONE = 1'b1;
    step();
    iDONE = 1'b0;
  endtask

  initial begin
    int ch, n, starts;
    int order [6];
    int rrExp [6];
    int prExp [4];
    rrExp = '{0, 1, 0, 1, 0, 1};
`ifdef UPP_ARB_DEPTH_PRIO_EN
    prExp = '{1, 1, 0, 1};
`else
    prExp = '{0, 1, 1, 1};
`endif

    // Reset state
    doReset();
    @(negedge iCLK);
    check("rst_busy", {31'd0, oBUSY}, 0);
    check("rst_sel", {31'd0, oSEL_CHANNEL}, 0);
    check("rst_pend0", {28'd0, oPEND_0}, 0);
    check("rst_timeout", {31'd0, oTIMEOUT}, 0);

    // Single frame on channel 0
    step();
    iCH_ENA = 2'b11; iFRAME_END = 2'b01;
    step();
    iFRAME_END = 2'b00;
    @(negedge iCLK);
    check("single_pend_before", {28'd0, oPEND_0}, 1);
    check("single_no_early_start", {31'd0, oSTART}, 0);
    step();
    @(negedge iCLK);
    check("single_start", {31'd0, oSTART}, 1);
    check("single_sel", {31'd0, oSEL_CHANNEL}, 0);
    step();
    iRD_REQ = 1'b1; iFIFO_OUT_0 = 16'hA5A5; iFIFO_OUT_1 = 16'h5A5A;
    @(negedge iCLK);
    check("single_rdreq", {30'd0, oRD_REQ}, 1);
    check("single_data", {16'd0, oFIFO_OUT}, 32'h0000A5A5);
    check("single_pend_after", {28'd0, oPEND_0}, 0);
    step();
    iRD_REQ = 1'b0; iDONE = 1'b1; iFRAME_END = 2'b01;
    step();
    iDONE = 1'b0; iFRAME_END = 2'b00;
    @(negedge iCLK);
    check("single_busy_low", {31'd0, oBUSY}, 0);
    n = 1;
    while (oSTART !== 1'b1 && n < 40) begin
      @(negedge iCLK);
      n++;
    end
    check("gap_distance", n, GAP + 2);
    finishFrame();

    // Round-robin with three frames per channel
    doReset();
    repeat (3) pulseFrame(2'b11);
    @(negedge iCLK);
    check("rr_pend0", {28'd0, oPEND_0}, 3);
    check("rr_pend1", {28'd0, oPEND_1}, 3);
    step();
    iCH_ENA = 2'b11;
    for (int i = 0; i < 6; i++) begin
      waitStart(order[i]);
      finishFrame();
    end
    for (int i = 0; i < 6; i++) check($sformatf("rr_order_%0d", i), order[i], rrExp[i]);

    // Uneven queues: pend0=1, pend1=3
    doReset();
    pulseFrame(2'b11);
    repeat (2) pulseFrame(2'b10);
    step();
    iCH_ENA = 2'b11;
    for (int i = 0; i < 4; i++) begin
      waitStart(order[i]);
      finishFrame();
    end
    for (int i = 0; i < 4; i++) check($sformatf("prio_order_%0d", i), order[i], prExp[i]);

    // Saturation and simultaneous frame-end with grant
    doReset();
    repeat (16) pulseFrame(2'b10);
    @(negedge iCLK);
    check("sat_pend1", {28'd0, oPEND_1}, 15);
    check("sat_overflow", {30'd0, oOVERFLOW}, 2);
    step();
    iCH_ENA = 2'b10;
    step();
    iFRAME_END = 2'b10;
    @(negedge iCLK);
    check("sat_grant_start", {31'd0, oSTART}, 1);
    step();
    iFRAME_END = 2'b00;
    @(negedge iCLK);
    check("sat_inc_dec_cancel", {28'd0, oPEND_1}, 15);
    finishFrame();

    // Watchdog abort
    doReset();
    repeat (2) pulseFrame(2'b01);
    step();
    iCH_ENA = 2'b11;
    waitStart(ch);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge iCLK);
      n++;
      if (oACLR_FIFO !== 2'b00) break;
    end
    check("wd_cycles", n, TO);
    check("wd_aclr", {30'd0, oACLR_FIFO}, 1);
    @(negedge iCLK);
    check("wd_pend0", {28'd0, oPEND_0}, 0);
    check("wd_timeout", {31'd0, oTIMEOUT}, 1);
    check("wd_aclr_one_cycle", {30'd0, oACLR_FIFO}, 0);

    // Done arriving on the timeout cycle wins
    step();
    iCH_ENA = 2'b00;
    repeat (2) pulseFrame(2'b01);
    repeat (8) step();
    iCH_ENA = 2'b11;
    waitStart(ch);
    repeat (TO) step();
    iDONE = 1'b1;
    @(negedge iCLK);
    check("wd_done_no_aclr", {30'd0, oACLR_FIFO}, 0);
    step();
    iDONE = 1'b0;
    @(negedge iCLK);
    check("wd_done_busy", {31'd0, oBUSY}, 0);
    check("wd_done_pend0", {28'd0, oPEND_0}, 1);

    // Channel mask and reset mid-frame
    doReset();
    iCH_ENA = 2'b10;
    repeat (2) pulseFrame(2'b01);
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge iCLK);
      if (oSTART === 1'b1) starts++;
    end
    check("mask_no_start", starts, 0);
    check("mask_pend0", {28'd0, oPEND_0}, 2);
    pulseFrame(2'b10);
    waitStart(ch);
    check("mask_sel1", ch, 1);
    step();
    iRST = 1'b1;
    @(negedge iCLK);
    check("rst_mid_no_aclr", {30'd0, oACLR_FIFO}, 0);
    step();
    iRST = 1'b0;
    @(negedge iCLK);
    check("rst_mid_start", {31'd0, oSTART}, 0);
    check("rst_mid_busy", {31'd0, oBUSY}, 0);
    check("rst_mid_sel", {31'd0, oSEL_CHANNEL}, 0);
    check("rst_mid_rdreq", {30'd0, oRD_REQ}, 0);
    check("rst_mid_aclr", {30'd0, oACLR_FIFO}, 0);
    check("rst_mid_pend0", {28'd0, oPEND_0}, 0);
    check("rst_mid_pend1", {28'd0, oPEND_1}, 0);
    check("rst_mid_ovf", {30'd0, oOVERFLOW}, 0);
    check("rst_mid_timeout", {31'd0, oTIMEOUT}, 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
